// File: rtl/ram_wrbuf_if.sv
// ram_wrbuf_if: CPU-side and RAM-side bus bundle for the posted-write buffer.
// slave modport is the buffer's view; master modport is the view of whatever
// drives the CPU requests and plays the ram.
interface ram_wrbuf_if #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 32
);
  logic          cpu_stb;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_in;
  logic [DW-1:0] cpu_data_out;
  logic          cpu_ack;
  logic          ram_stb;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_ack;
  logic          wb_empty;

  modport slave (
    input  cpu_stb, cpu_we, cpu_addr, cpu_data_in, ram_rdata, ram_ack,
    output cpu_data_out, cpu_ack, ram_stb, ram_we, ram_addr, ram_wdata, wb_empty
  );

  modport master (
    output cpu_stb, cpu_we, cpu_addr, cpu_data_in, ram_rdata, ram_ack,
    input  cpu_data_out, cpu_ack, ram_stb, ram_we, ram_addr, ram_wdata, wb_empty
  );
endinterface

// File: rtl/ram_wrbuf.sv
// ram_wrbuf: posted-write buffer in front of the ram.
// CPU writes are acknowledged on entry into a DEPTH-deep FIFO and drained to the
// ram in order; CPU reads are held until ordering against buffered writes is safe.
// Optional feature macro: RAM_WRBUF_FWD_EN -- reads compare against buffered
// entries, hits are served from the buffer, misses bypass the queued writes.
module ram_wrbuf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 22,
  parameter int unsigned DW    = 32
) (
  input logic        clk,
  input logic        rst_n,
  ram_wrbuf_if.slave bus
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDDONE
  } state_t;

  state_t        state_q, state_d;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic [IW-1:0] head_idx;

  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          wr_req;
  logic          rd_req;
  logic          push;
  logic          pop;
  logic          rd_go;
  logic          fwd_take;
  logic [DW-1:0] fwd_data;

  logic          ram_stb_c;
  logic          ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic [DW-1:0] ram_wdata_c;

  // FIFO status from the extra pointer MSB
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                      (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign head_idx   = rd_ptr_q[IW-1:0];

  // CPU request decode: a request is only looked at while no ack is showing
  assign wr_req = bus.cpu_stb &&  bus.cpu_we && !cpu_ack_q;
  assign rd_req = bus.cpu_stb && !bus.cpu_we && !cpu_ack_q;

  // A pop and a push may share a cycle even when full: the pop frees the slot first
  assign pop  = (state_q == S_WR) && bus.ram_ack;
  assign push = wr_req && (!fifo_full || pop);

`ifdef RAM_WRBUF_FWD_EN
  logic [PW-1:0] fifo_count;
  logic          fwd_hit;

  assign fifo_count = wr_ptr_q - rd_ptr_q;

  // Scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    logic [IW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_idx + IW'(i);
      if ((i < 32'(fifo_count)) && (addr_mem[idx] == bus.cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

  // Hits complete from the buffer; misses may overtake queued writes safely
  assign fwd_take = rd_req && fwd_hit;
  assign rd_go    = rd_req && !fwd_hit;
`else
  // Without forwarding a read only proceeds once every buffered write is in the ram
  assign fwd_take = 1'b0;
  assign fwd_data = '0;
  assign rd_go    = rd_req && fifo_empty;
`endif

  // FIFO pointer and ack/read-data next-state
  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    cpu_ack_d = push || fwd_take || ((state_q == S_RD) && bus.ram_ack);
    rdata_d   = rdata_q;
    if ((state_q == S_RD) && bus.ram_ack) begin
      rdata_d = bus.ram_rdata;
    end else if (fwd_take) begin
      rdata_d = fwd_data;
    end
  end

  // RAM-side FSM: next state and bus outputs (reads take priority in IDLE)
  always_comb begin
    state_d     = state_q;
    ram_stb_c   = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    unique case (state_q)
      S_IDLE: begin
        if (rd_go) begin
          state_d = S_RD;
        end else if (!fifo_empty) begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        ram_stb_c   = 1'b1;
        ram_we_c    = 1'b1;
        ram_addr_c  = addr_mem[head_idx];
        ram_wdata_c = data_mem[head_idx];
        if (bus.ram_ack) begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        ram_stb_c  = 1'b1;
        ram_addr_c = bus.cpu_addr;
        if (bus.ram_ack) begin
          state_d = S_RDDONE;
        end
      end
      S_RDDONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointers and CPU-facing registers; reset abandons everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cpu_ack_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cpu_ack_q <= cpu_ack_d;
      rdata_q   <= rdata_d;
    end
  end

  // Buffer storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q[IW-1:0]] <= bus.cpu_addr;
      data_mem[wr_ptr_q[IW-1:0]] <= bus.cpu_data_in;
    end
  end

  assign bus.cpu_ack      = cpu_ack_q;
  assign bus.cpu_data_out = rdata_q;
  assign bus.ram_stb      = ram_stb_c;
  assign bus.ram_we       = ram_we_c;
  assign bus.ram_addr     = ram_addr_c;
  assign bus.ram_wdata    = ram_wdata_c;
  assign bus.wb_empty     = fifo_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_ram_wrbuf.sv
// tb_ram_wrbuf: directed and random checks of ram_wrbuf against a ram model and
// a program-order reference (expected write stream plus shadow memory).
module tb_ram_wrbuf;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_wrbuf_if #(.AW(AW), .DW(DW)) bus ();

  ram_wrbuf #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // ram model state
  int          lat  = 2;
  bit          hold = 1'b0;
  int          cnt  = 0;
  int          ma;
  logic [31:0] mem [int];
  logic [31:0] obs_a [$];
  logic [31:0] obs_d [$];
  int          rd_cnt   = 0;
  int          wr_at_rd = 0;

  // reference: CPU-order write stream and latest value per address
  logic [31:0] exp_a [$];
  logic [31:0] exp_d [$];
  logic [31:0] sh [int];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  // ram: acks a request lat cycles after stb, single-cycle ack, hold stalls it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_ack <= 1'b0;
      cnt <= 0;
    end else begin
      bus.ram_ack <= 1'b0;
      if (bus.ram_stb && !bus.ram_ack && !hold) begin
        if (cnt + 1 >= lat) begin
          bus.ram_ack <= 1'b1;
          cnt <= 0;
          ma = int'(bus.ram_addr);
          if (bus.ram_we) begin
            mem[ma] = bus.ram_wdata;
            obs_a.push_back(32'(bus.ram_addr));
            obs_d.push_back(bus.ram_wdata);
          end else begin
            bus.ram_rdata <= mem.exists(ma) ? mem[ma] : dflt(32'(ma));
            rd_cnt = rd_cnt + 1;
            wr_at_rd = obs_a.size();
          end
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, output int cyc);
    logic [31:0] av;
    av = a;
    @(negedge clk);
    bus.cpu_stb = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr = av[AW-1:0]; bus.cpu_data_in = d;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!bus.cpu_ack && cyc < 300);
    chk("wr_ack_seen", 32'(bus.cpu_ack), 32'd1);
    if (bus.cpu_ack) begin
      exp_a.push_back(a); exp_d.push_back(d); sh[int'(a)] = d;
    end
    bus.cpu_stb = 1'b0; bus.cpu_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output int cyc);
    logic [31:0] av;
    av = a;
    @(negedge clk);
    bus.cpu_stb = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = av[AW-1:0];
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!bus.cpu_ack && cyc < 300);
    chk("rd_ack_seen", 32'(bus.cpu_ack), 32'd1);
    d = bus.cpu_data_out;
    bus.cpu_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!bus.wb_empty && n < 500) begin @(posedge clk); #1; n++; end
    chk("drain_done", 32'(bus.wb_empty), 32'd1);
  endtask

  task automatic check_order(input string tag);
    int m;
    wait_drain();
    chk({tag, "_wr_count"}, 32'(obs_a.size()), 32'(exp_a.size()));
    m = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_wr_addr"}, obs_a[i], exp_a[i]);
      chk({tag, "_wr_data"}, obs_d[i], exp_d[i]);
    end
    obs_a.delete(); obs_d.delete(); exp_a.delete(); exp_d.delete();
  endtask

  initial begin
    int          cyc, seen, n, r0;
    logic [31:0] d, a, e;
    logic [31:0] addrs [4];
    addrs[0] = 32'h1000; addrs[1] = 32'h2000; addrs[2] = 32'h2004; addrs[3] = 32'h3000;

    bus.cpu_stb = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_stb",  32'(bus.ram_stb),  32'd0);
    chk("rst_ram_we",   32'(bus.ram_we),   32'd0);
    chk("rst_cpu_ack",  32'(bus.cpu_ack),  32'd0);
    chk("rst_wb_empty", 32'(bus.wb_empty), 32'd1);
    chk("rst_data_out", bus.cpu_data_out,  32'd0);
    @(negedge clk); rst_n = 1'b1;

    // single posted write, ram acks 2 cycles after stb
    lat = 2;
    cpu_write(32'h1000, 32'h4444_4444, cyc);
    chk("t1_ack_lat", 32'(cyc), 32'd1);
    check_order("t1");

    // ram stalled: four writes fill the buffer, the fifth waits for a pop
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cpu_write(32'h100 + 32'(i), 32'h1111_1111 * 32'(i), cyc);
      chk("t2_ack_lat", 32'(cyc), 32'd1);
    end
    @(negedge clk);
    bus.cpu_stb = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 22'h105; bus.cpu_data_in = 32'h5555_5555;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (bus.cpu_ack) seen++; end
    chk("t2_full_noack", 32'(seen), 32'd0);
    hold = 1'b0;
    n = 0;
    while (!bus.cpu_ack && n < 100) begin @(posedge clk); #1; n++; end
    chk("t2_full_ack", 32'(bus.cpu_ack), 32'd1);
    chk("t2_ack_after_pop", 32'(obs_a.size() >= 1), 32'd1);
    if (bus.cpu_ack) begin
      exp_a.push_back(32'h105); exp_d.push_back(32'h5555_5555); sh[32'h105] = 32'h5555_5555;
    end
    bus.cpu_stb = 1'b0; bus.cpu_we = 1'b0;
    @(posedge clk); #1;
    check_order("t2");

    // read-after-write to the same address
    cpu_write(32'h1000, 32'h5555_5555, cyc);
    r0 = rd_cnt;
    cpu_read(32'h1000, d, cyc);
    chk("t3_rd_data", d, 32'h5555_5555);
`ifdef RAM_WRBUF_FWD_EN
    chk("t3_fwd_lat", 32'(cyc), 32'd1);
    chk("t3_no_ram_rd", 32'(rd_cnt), 32'(r0));
`else
    chk("t3_ram_rd", 32'(rd_cnt), 32'(r0 + 1));
    chk("t3_rd_after_wr", 32'(wr_at_rd), 32'(exp_a.size()));
`endif
    check_order("t3");

    // two writes to one address, read returns the younger value
`ifdef RAM_WRBUF_FWD_EN
    hold = 1'b1;
    cpu_write(32'h2000, 32'hAAAA_AAAA, cyc);
    cpu_write(32'h2000, 32'hBBBB_BBBB, cyc);
    cpu_read(32'h2000, d, cyc);
    chk("t4_fwd_lat", 32'(cyc), 32'd1);
    hold = 1'b0;
`else
    cpu_write(32'h2000, 32'hAAAA_AAAA, cyc);
    cpu_write(32'h2000, 32'hBBBB_BBBB, cyc);
    cpu_read(32'h2000, d, cyc);
`endif
    chk("t4_rd_data", d, 32'hBBBB_BBBB);
    check_order("t4");

    // read miss while writes are still queued behind a slow ram
    lat = 6;
    cpu_write(32'h2100, 32'h0123_4567, cyc);
    cpu_write(32'h2104, 32'h89AB_CDEF, cyc);
    r0 = rd_cnt;
    cpu_read(32'h3000, d, cyc);
    chk("t5_rd_data", d, dflt(32'h3000));
    chk("t5_ram_rd", 32'(rd_cnt), 32'(r0 + 1));
`ifdef RAM_WRBUF_FWD_EN
    chk("t5_rd_bypass", 32'(wr_at_rd < 2), 32'd1);
`else
    chk("t5_rd_after_drain", 32'(wr_at_rd), 32'd2);
`endif
    lat = 2;
    check_order("t5");

    // reset in the middle of a ram write with three entries buffered
    hold = 1'b1;
    cpu_write(32'h5000, 32'hDEAD_0001, cyc);
    cpu_write(32'h5001, 32'hDEAD_0002, cyc);
    cpu_write(32'h5002, 32'hDEAD_0003, cyc);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_busy", 32'(bus.ram_stb), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ram_stb",  32'(bus.ram_stb),  32'd0);
    chk("t6_rst_cpu_ack",  32'(bus.cpu_ack),  32'd0);
    chk("t6_rst_wb_empty", 32'(bus.wb_empty), 32'd1);
    exp_a.delete(); exp_d.delete(); obs_a.delete(); obs_d.delete();
    hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_wr_after_rst", 32'(obs_a.size()), 32'd0);
    chk("t6_idle_after_rst",  32'(bus.wb_empty), 32'd1);

    // random mix of reads and writes over a few addresses
    for (int k = 0; k < 80; k++) begin
      lat = int'($urandom_range(1, 3));
      a = addrs[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) begin
        cpu_write(a, $urandom, cyc);
      end else begin
        e = sh.exists(int'(a)) ? sh[int'(a)] : dflt(a);
        r0 = rd_cnt;
        cpu_read(a, d, cyc);
        chk("rnd_rd_data", d, e);
`ifndef RAM_WRBUF_FWD_EN
        chk("rnd_rd_order", 32'(wr_at_rd), 32'(exp_a.size()));
`endif
      end
    end
    check_order("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
